// File: rtl/aes_key_sched_ctrl_if.sv
// Handshake bundle between the AES key-schedule controller,
// the key source, KeyExpansion and the round datapath.
interface aes_key_sched_ctrl_if;
  logic [127:0]  i_Key;
  logic          i_fKeyValid;
  logic          o_fKeyReady;
  logic [127:0]  o_KE_Key;
  logic          o_KE_fIsFirst;
  logic          o_KE_fStart;
  logic [1407:0] i_KE_Key;
  logic          i_KE_fDone;
  logic          o_fSchedValid;
  logic          i_fRunReq;
  logic [127:0]  o_RoundKey;
  logic [3:0]    o_Round;
  logic          o_fRoundValid;
  logic          i_fRoundAck;
  logic          o_fRunDone;
  logic          o_fErr;

  modport master (
    output i_Key, i_fKeyValid,
    output i_KE_Key, i_KE_fDone,
    output i_fRunReq, i_fRoundAck,
    input  o_fKeyReady, o_KE_Key,
    input  o_KE_fIsFirst, o_KE_fStart,
    input  o_fSchedValid, o_RoundKey,
    input  o_Round, o_fRoundValid,
    input  o_fRunDone, o_fErr
  );

  modport slave (
    input  i_Key, i_fKeyValid,
    input  i_KE_Key, i_KE_fDone,
    input  i_fRunReq, i_fRoundAck,
    output o_fKeyReady, o_KE_Key,
    output o_KE_fIsFirst, o_KE_fStart,
    output o_fSchedValid, o_RoundKey,
    output o_Round, o_fRoundValid,
    output o_fRunDone, o_fErr
  );
endinterface

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: loads a key, runs KeyExpansion,
// holds the schedule and serves round keys 0..10 on request.
module aes_key_sched_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input logic                 Clk,
  input logic                 Rst,
  aes_key_sched_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    KE_START,
    KE_WAIT,
    READY,
    RUN,
    ERR
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [1407:0]   sched;
  logic [TO_W-1:0] to_cnt;
  logic [127:0]    rk [11];
  logic            key_ready;
  logic            key_acc;
  logic            last_rnd;
  logic [3:0]      nxt_rnd;

  for (genvar r = 0; r < 11; r++) begin : g_rk
    assign rk[r] = sched[1407-128*r -: 128];
  end

  // Ready is masked during reset so every output reads 0 there.
  assign key_ready = Rst & ((state == IDLE) |
                            (state == READY) |
                            (state == ERR));
  assign key_acc   = bus.i_fKeyValid & key_ready;
  assign last_rnd  = bus.o_Round >= 4'd10;
  assign nxt_rnd   = bus.o_Round + 4'd1;

  assign bus.o_fKeyReady = key_ready;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state             <= IDLE;
      sched             <= '0;
      to_cnt            <= '0;
      bus.o_KE_Key      <= '0;
      bus.o_KE_fIsFirst <= 1'b0;
      bus.o_KE_fStart   <= 1'b0;
      bus.o_fSchedValid <= 1'b0;
      bus.o_RoundKey    <= '0;
      bus.o_Round       <= '0;
      bus.o_fRoundValid <= 1'b0;
      bus.o_fRunDone    <= 1'b0;
      bus.o_fErr        <= 1'b0;
    end else begin
      bus.o_KE_fIsFirst <= 1'b0;
      bus.o_KE_fStart   <= 1'b0;
      bus.o_fRunDone    <= 1'b0;
      unique case (state)
        IDLE, READY, ERR: begin
          if (key_acc) begin
            state             <= KE_START;
            bus.o_KE_Key      <= bus.i_Key;
            bus.o_fSchedValid <= 1'b0;
            bus.o_fErr        <= 1'b0;
            bus.o_KE_fIsFirst <= 1'b1;
            bus.o_KE_fStart   <= 1'b1;
          end else if (state == READY &&
                       bus.i_fRunReq) begin
            state             <= RUN;
            bus.o_Round       <= 4'd0;
            bus.o_RoundKey    <= rk[0];
            bus.o_fRoundValid <= 1'b1;
          end
        end
        KE_START: begin
          to_cnt <= '0;
          state  <= KE_WAIT;
        end
        KE_WAIT: begin
          to_cnt <= to_cnt + TO_W'(1);
          // Done wins over a same-cycle expiry.
          if (bus.i_KE_fDone) begin
            sched             <= bus.i_KE_Key;
            bus.o_fSchedValid <= 1'b1;
            state             <= READY;
          end else if (to_cnt == TO_LAST) begin
            bus.o_fErr <= 1'b1;
            state      <= ERR;
          end
        end
        RUN: begin
          if (bus.i_fRoundAck) begin
            // Out-of-range counts finish as round 10.
            if (last_rnd) begin
              bus.o_fRoundValid <= 1'b0;
              bus.o_fRunDone    <= 1'b1;
              state             <= READY;
            end else begin
              bus.o_Round    <= nxt_rnd;
              bus.o_RoundKey <= rk[nxt_rnd];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl with an AES
// KeyExpansion reference model and round-key scoreboard.
module tb_aes_key_sched_ctrl;

  localparam int TIMEOUT = 64;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  aes_key_sched_ctrl_if bus();

  aes_key_sched_ctrl #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    logic [127:0] key;
    int           dly;
    logic [127:0] rk0;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  int            n_pass = 0;
  int            n_tot  = 0;
  logic [7:0]    sbox [256];
  logic [1407:0] sch_cur;
  logic [127:0]  got [11];
  vec_t          vecs [3];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in,
                                      input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sbox[t[23:16]], sbox[t[15:8]],
             sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = w[i];
    return res;
  endfunction

  function automatic logic [127:0] rkey(input int r);
    return sch_cur[1407-128*r -: 128];
  endfunction

  task automatic load_key(input logic [127:0] k, input int dly,
                          input bit with_run);
    logic [1407:0] s;
    int n;
    s = expand(k);
    chk("key_ready_before", bus.o_fKeyReady, 1);
    bus.i_Key = k;
    bus.i_fKeyValid = 1'b1;
    bus.i_fRunReq = with_run;
    @(negedge Clk);
    bus.i_fKeyValid = 1'b0;
    bus.i_fRunReq = 1'b0;
    chk("ke_start", bus.o_KE_fStart, 1);
    chk("ke_first", bus.o_KE_fIsFirst, 1);
    chk("ke_key", bus.o_KE_Key, k);
    chk("no_run_on_load", bus.o_fRoundValid, 0);
    chk("sched_cleared", bus.o_fSchedValid, 0);
    chk("err_cleared", bus.o_fErr, 0);
    chk("key_ready_busy", bus.o_fKeyReady, 0);
    if (dly > 0) begin
      for (int c = 1; c <= dly; c++) begin
        @(negedge Clk);
        chk("start_once", bus.o_KE_fStart, 0);
        chk("sched_wait", bus.o_fSchedValid, 0);
        chk("no_err_wait", bus.o_fErr, 0);
        if (c == dly) begin
          bus.i_KE_fDone = 1'b1;
          bus.i_KE_Key = s;
        end
      end
      @(negedge Clk);
      bus.i_KE_fDone = 1'b0;
      chk("sched_valid", bus.o_fSchedValid, 1);
      chk("no_err_done", bus.o_fErr, 0);
      chk("ready_after_ke", bus.o_fKeyReady, 1);
      sch_cur = s;
    end else begin
      n = 0;
      while (bus.o_fErr !== 1'b1 && n < 200) begin
        @(negedge Clk);
        n++;
      end
      chk("err_latency", n, TIMEOUT + 1);
      chk("sched_on_err", bus.o_fSchedValid, 0);
      chk("ready_in_err", bus.o_fKeyReady, 1);
    end
  endtask

  task automatic run_seq(input int mode, input bit kv_during);
    int r, acks, cyc;
    bit ack, done;
    bus.i_fRunReq = 1'b1;
    @(negedge Clk);
    bus.i_fRunReq = 1'b0;
    r = 0; acks = 0; cyc = 0; done = 0;
    while (!done && cyc < 300) begin
      chk("rvalid", bus.o_fRoundValid, 1);
      chk("round_idx", bus.o_Round, r);
      chk("round_key", bus.o_RoundKey, rkey(r));
      chk("no_early_done", bus.o_fRunDone, 0);
      if (r < 11) got[r] = bus.o_RoundKey;
      if (kv_during && cyc > 0) begin
        chk("ready_in_run", bus.o_fKeyReady, 0);
        chk("no_ke_in_run", bus.o_KE_fStart, 0);
      end
      if (kv_during) begin
        bus.i_fKeyValid = 1'b1;
        bus.i_Key = {$urandom, $urandom, $urandom, $urandom};
      end
      case (mode)
        0: ack = 1'b1;
        1: ack = (cyc % 3 == 2);
        default: ack = 1'($urandom);
      endcase
      bus.i_fRoundAck = ack;
      if (ack) begin
        acks++;
        r++;
        if (r == 11) done = 1;
      end
      cyc++;
      @(negedge Clk);
    end
    bus.i_fRoundAck = 1'b0;
    bus.i_fKeyValid = 1'b0;
    if (!done) chk("run_timeout", 0, 1);
    chk("valid_fell", bus.o_fRoundValid, 0);
    chk("run_done", bus.o_fRunDone, 1);
    chk("ack_count", acks, 11);
    if (kv_during) chk("no_ke_after", bus.o_KE_fStart, 0);
    @(negedge Clk);
    chk("run_done_pulse", bus.o_fRunDone, 0);
    chk("ready_after_run", bus.o_fKeyReady, 1);
    chk("sched_kept", bus.o_fSchedValid, 1);
  endtask

  initial begin
    logic [127:0] k;
    int n;
    bus.i_Key = '0;
    bus.i_fKeyValid = 1'b0;
    bus.i_KE_Key = '0;
    bus.i_KE_fDone = 1'b0;
    bus.i_fRunReq = 1'b0;
    bus.i_fRoundAck = 1'b0;
    build_sbox();

    vecs[0] = '{128'h5468617473206D79204B756E67204675, 12,
                128'h5468617473206D79204B756E67204675,
                128'hE232FCF191129188B159E4E6D679A293,
                128'h28FDDEF86DA4244ACCC0A4FE3B316F26};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1,
                128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[2] = '{128'h0, TIMEOUT,
                128'h0,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    @(negedge Clk);
    chk("rst_ready", bus.o_fKeyReady, 0);
    chk("rst_ke_key", bus.o_KE_Key, 0);
    chk("rst_start", bus.o_KE_fStart, 0);
    chk("rst_sched", bus.o_fSchedValid, 0);
    chk("rst_rkey", bus.o_RoundKey, 0);
    chk("rst_round", bus.o_Round, 0);
    chk("rst_valid", bus.o_fRoundValid, 0);
    chk("rst_err", bus.o_fErr, 0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("idle_ready", bus.o_fKeyReady, 1);
    bus.i_fRunReq = 1'b1;
    @(negedge Clk);
    bus.i_fRunReq = 1'b0;
    chk("idle_no_run", bus.o_fRoundValid, 0);

    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key, vecs[i].dly, 0);
      run_seq(0, 0);
      chk("tbl_rk0", got[0], vecs[i].rk0);
      chk("tbl_rk1", got[1], vecs[i].rk1);
      chk("tbl_rk10", got[10], vecs[i].rk10);
    end

    run_seq(1, 0);

    bus.i_KE_fDone = 1'b1;
    bus.i_KE_Key = {44{$urandom}};
    bus.i_fRoundAck = 1'b1;
    @(negedge Clk);
    bus.i_KE_fDone = 1'b0;
    bus.i_fRoundAck = 1'b0;
    chk("stray_ack", bus.o_fRoundValid, 0);
    run_seq(0, 0);

    load_key(128'hdeadbeef_00112233_44556677_8899aabb, 0, 0);
    bus.i_fRunReq = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("err_no_run", bus.o_fRoundValid, 0);
      chk("err_sticky", bus.o_fErr, 1);
    end
    bus.i_fRunReq = 1'b0;
    load_key(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 5, 0);
    run_seq(2, 0);

    load_key(128'hcafef00d_12345678_9abcdef0_0badc0de, 7, 1);
    run_seq(0, 1);

    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, int'($urandom_range(1, 30)), 0);
      run_seq(2, 0);
      if (i % 2 == 0) run_seq(1, 0);
    end

    bus.i_fRunReq = 1'b1;
    @(negedge Clk);
    bus.i_fRunReq = 1'b0;
    bus.i_fRoundAck = 1'b1;
    n = 0;
    while (bus.o_Round != 4'd5 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    chk("reach_round5", bus.o_Round, 5);
    #2 Rst = 1'b0;
    #1;
    bus.i_fRoundAck = 1'b0;
    chk("arst_valid", bus.o_fRoundValid, 0);
    chk("arst_rkey", bus.o_RoundKey, 0);
    chk("arst_round", bus.o_Round, 0);
    chk("arst_sched", bus.o_fSchedValid, 0);
    chk("arst_ke_key", bus.o_KE_Key, 0);
    chk("arst_ready", bus.o_fKeyReady, 0);
    chk("arst_done", bus.o_fRunDone, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("rst_no_done", bus.o_fRunDone, 0);
    end
    Rst = 1'b1;
    @(negedge Clk);
    chk("post_rst_ready", bus.o_fKeyReady, 1);
    chk("post_rst_sched", bus.o_fSchedValid, 0);
    chk("post_rst_done", bus.o_fRunDone, 0);
    chk("post_rst_valid", bus.o_fRoundValid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/aes_key_sched_ctrl.md
Name: aes_key_sched_ctrl

Overview:
- Controller that sequences the KeyExpansion block and serves round keys to the AES round datapath.
- Accepts a 128-bit cipher key over a valid/ready handshake, then starts KeyExpansion with a one-cycle fIsFirst/fStart pulse, waits for fDone, and latches the 1408-bit schedule.
- On each run request it issues round keys 0..10 to the round engine, one per valid/ack handshake.
- Sits between the top-level AES control and KeyExpansion/round datapath.

Parameters:
- TIMEOUT, 64, max cycles to wait for KE fDone after the start pulse before flagging an error.
- TO_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset.
- i_Key  input  128  cipher key, sampled on key-load handshake.
- i_fKeyValid  input  1  key-load request.
- o_fKeyReady  output  1  key load can be accepted this cycle.
- o_KE_Key  output  128  key driven to KeyExpansion.
- o_KE_fIsFirst  output  1  KeyExpansion first-key strobe.
- o_KE_fStart  output  1  KeyExpansion start strobe.
- i_KE_Key  input  1408  KeyExpansion schedule; round 0 = [1407:1280], round r = [1407-128r -: 128].
- i_KE_fDone  input  1  KeyExpansion completion.
- o_fSchedValid  output  1  a valid schedule is held.
- i_fRunReq  input  1  request a round-key sequence.
- o_RoundKey  output  128  current round key.
- o_Round  output  4  current round index 0..10.
- o_fRoundValid  output  1  o_RoundKey/o_Round valid.
- i_fRoundAck  input  1  consumer accepts the current round key.
- o_fRunDone  output  1  one-cycle pulse after round 10 is acked.
- o_fErr  output  1  KE timeout error, sticky.

Behaviour:
- Reset (Rst=0, async):
  - State goes to IDLE.
  - All outputs 0, including o_KE_Key, o_RoundKey and o_Round.
  - Key and schedule registers are cleared; timeout counter is cleared.
- States: IDLE, KE_START, KE_WAIT, READY, RUN, ERR.
- o_fKeyReady = 1 in IDLE, READY and ERR; 0 otherwise. It is combinational from state.
- Key accept = i_fKeyValid & o_fKeyReady.
  - Latches i_Key into o_KE_Key.
  - Clears o_fSchedValid and o_fErr.
  - Next state is KE_START.
- KE_START lasts exactly one cycle:
  - o_KE_fIsFirst = o_KE_fStart = 1 (registered outputs, high only in this cycle).
  - Timeout counter is cleared.
  - Next state is KE_WAIT.
- KE_WAIT:
  - Counter increments each cycle.
  - If i_KE_fDone=1: latch i_KE_Key into the schedule register, set o_fSchedValid, go to READY.
  - Else if counter reaches TIMEOUT-1: set o_fErr, go to ERR.
  - fDone in the same cycle as expiry means done wins.
- i_KE_fDone outside KE_WAIT is ignored, with no schedule update.
- READY:
  - Key accept takes priority over i_fRunReq; a simultaneous run request is dropped, not queued.
  - Otherwise i_fRunReq=1 goes to RUN with the round counter = 0.
- RUN:
  - o_fRoundValid = 1.
  - o_Round = counter.
  - o_RoundKey = schedule slice for that counter, registered and updated on the same edge as the counter.
  - Outputs hold stable until i_fRoundAck=1.
  - Ack with counter < 10: counter+1 and next key appear the following cycle, valid stays high. Throughput is 1 key/cycle if ack is held high.
  - Ack with counter = 10: o_fRoundValid falls next cycle, o_fRunDone pulses for 1 cycle, state goes to READY.
  - i_fKeyValid and i_fRunReq are ignored during RUN.
- i_fRoundAck is ignored when o_fRoundValid=0.
- ERR:
  - o_fErr stays high and i_fRunReq is ignored.
  - Only a key accept exits ERR.
- Reset mid-operation (any state) aborts immediately. No o_fRunDone is generated.
- A counter value >10 is unreachable. If it occurs, treat it as round 10.

Test Plan:
1. Reset then load key 5468617473206D79204B756E67204675; model fDone 12 cycles after the start pulse.
   - Exactly one cycle with fIsFirst=fStart=1 and o_KE_Key equal to the key.
   - o_fSchedValid=1 the cycle after fDone.
2. Run with ack held high.
   - Rounds 0..10 on 11 consecutive cycles.
   - Round 0 = 5468617473206D79204B756E67204675, round 1 = E232FCF191129188B159E4E6D679A293, round 10 = 28FDDEF86DA4244ACCC0A4FE3B316F26.
   - o_fRunDone pulses once, 1 cycle after round-10 ack.
3. Run with ack every 3rd cycle.
   - o_RoundKey and o_Round are stable while unacked.
   - Each round is consumed exactly once; 11 acks total.
4. Never assert fDone after the start pulse.
   - o_fErr=1 after TIMEOUT cycles in KE_WAIT; i_fRunReq is ignored.
   - A new key load clears o_fErr and restarts the sequence.
5. In READY, assert i_fKeyValid and i_fRunReq in the same cycle.
   - Key load is taken and o_fRoundValid stays 0.
   - During RUN, i_fKeyValid sees o_fKeyReady=0 and no KE pulse occurs.
6. Drop Rst low mid-RUN at round 5.
   - All outputs 0 asynchronously, state is IDLE, o_fSchedValid=0, and no o_fRunDone occurs.
